// File: rtl/piso_serializer_param.sv
// Parameterised parallel-in/serial-out serializer with a valid/ready load handshake and stall support.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer_param #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] shift_reg,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit,
    output logic             busy,
    output logic             frame_done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    // One spare count value lets the counter step past the final bit.
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             advance;
    logic             data_bit;

    assign busy         = (state == SHIFT);
    assign serial_valid = busy;
    assign last_bit     = busy && (bit_cnt == CNT_W'(FRAME_LEN - 1));
    assign load_ready   = !busy || (last_bit && enable);
    assign accept       = load_valid && load_ready;
    assign advance      = busy && enable;
    assign data_bit     = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

`ifdef PISO_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk) begin
        if (reset)
            parity_bit <= 1'b0;
        else if (accept)
            parity_bit <= ^parallel_in;
    end

    assign serial_out = busy ? ((bit_cnt == CNT_W'(WIDTH)) ? parity_bit : data_bit)
                             : IDLE_LEVEL;
`else
    assign serial_out = busy ? data_bit : IDLE_LEVEL;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_bit && enable;
            if (accept) begin
                // Reload on the last-bit cycle keeps back-to-back frames gap-free.
                state     <= SHIFT;
                shift_reg <= parallel_in;
                bit_cnt   <= '0;
            end else if (advance) begin
                if (MSB_FIRST)
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                else
                    shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
                if (last_bit)
                    state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer_param.sv
// Directed bench for piso_serializer_param: MSB-first and LSB-first instances share all inputs.
module tb_piso_serializer_param;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] parallel_in = 8'h00;

    logic       m_ready, m_sout, m_svalid, m_last, m_busy, m_done;
    logic [7:0] m_sreg;
    logic       l_ready, l_sout, l_svalid, l_last, l_busy, l_done;
    logic [7:0] l_sreg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
        .load_ready(m_ready), .parallel_in(parallel_in), .shift_reg(m_sreg),
        .serial_out(m_sout), .serial_valid(m_svalid), .last_bit(m_last),
        .busy(m_busy), .frame_done(m_done)
    );

    piso_serializer_param #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
        .load_ready(l_ready), .parallel_in(parallel_in), .shift_reg(l_sreg),
        .serial_out(l_sout), .serial_valid(l_svalid), .last_bit(l_last),
        .busy(l_busy), .frame_done(l_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected frame bit i of word w; index 8 is the even-parity bit.
    function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
        if (i >= 8) return ^w;
        return msb ? w[7-i] : w[i];
    endfunction

    initial begin
        int cnt;
        int idx;

        // Reset state
        step(); step();
        reset = 1'b0;
        chk("rst_busy", m_busy, 0);
        chk("rst_sreg", m_sreg, 8'h00);
        chk("rst_sout", m_sout, 0);
        chk("rst_svalid", m_svalid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_ready", m_ready, 1);
        chk("rst_done", m_done, 0);

        // Single frame 0x96, MSB first
        load_valid = 1'b1; parallel_in = 8'h96;
        enable = 1'b0;
        chk("idle_ready_no_en", m_ready, 1);
        enable = 1'b1;
        step();
        load_valid = 1'b0;
        chk("acc_sreg", m_sreg, 8'h96);
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("f1_bit%0d", i), m_sout, exp_bit(8'h96, i, 1'b1));
            chk($sformatf("f1_valid%0d", i), m_svalid, 1);
            chk($sformatf("f1_last%0d", i), m_last, (i == FL - 1));
            chk($sformatf("f1_done%0d", i), m_done, 0);
            step();
        end
        chk("f1_done_pulse", m_done, 1);
        chk("f1_idle_busy", m_busy, 0);
        chk("f1_idle_sout", m_sout, 0);
        step();
        chk("f1_done_clear", m_done, 0);

        // Single frame 0x62 on the LSB-first instance
        load_valid = 1'b1; parallel_in = 8'h62;
        step();
        load_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < FL + 2; i++) begin
            if (i < FL)
                chk($sformatf("lsb_bit%0d", i), l_sout, exp_bit(8'h62, i, 1'b0));
            if (l_svalid) cnt++;
            step();
        end
        chk("lsb_valid_cycles", cnt, FL);
        chk("lsb_idle_busy", l_busy, 0);

        // Back-to-back 0x96 then 0x62 with load_valid held
        load_valid = 1'b1; parallel_in = 8'h96;
        step();
        parallel_in = 8'h62;
        for (int i = 0; i < 2 * FL; i++) begin
            if (i < FL)
                chk($sformatf("b2b_bit%0d", i), m_sout, exp_bit(8'h96, i, 1'b1));
            else
                chk($sformatf("b2b_bit%0d", i), m_sout, exp_bit(8'h62, i - FL, 1'b1));
            chk($sformatf("b2b_valid%0d", i), m_svalid, 1);
            chk($sformatf("b2b_ready%0d", i), m_ready, (i == FL - 1) || (i == 2 * FL - 1));
            if (i == FL) chk("b2b_done_first_bit", m_done, 1);
            if (i == FL - 2) chk("b2b_done_early", m_done, 0);
            if (i == 2 * FL - 1) load_valid = 1'b0;
            step();
        end
        chk("b2b_done_end", m_done, 1);
        chk("b2b_idle", m_busy, 0);
        step();

        // Stall three cycles while bit index 3 is presented
        load_valid = 1'b1; parallel_in = 8'h96;
        step();
        load_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < FL + 3; c++) begin
            enable = !(c >= 3 && c <= 5);
            idx = (c < 3) ? c : ((c <= 6) ? 3 : c - 3);
            chk($sformatf("stall_bit_c%0d", c), m_sout, exp_bit(8'h96, idx, 1'b1));
            if (c >= 3 && c <= 5) chk($sformatf("stall_ready_c%0d", c), m_ready, 0);
            chk($sformatf("stall_last_c%0d", c), m_last, (c == FL + 2));
            if (m_busy) cnt++;
            step();
        end
        enable = 1'b1;
        chk("stall_span", cnt, FL + 3);
        chk("stall_done", m_done, 1);
        step();

        // Reset in the middle of a frame
        load_valid = 1'b1; parallel_in = 8'h96;
        step();
        load_valid = 1'b0;
        repeat (5) step();
        chk("mid_bit5", m_sout, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_busy", m_busy, 0);
        chk("mid_sreg", m_sreg, 8'h00);
        chk("mid_sout", m_sout, 0);
        chk("mid_ready", m_ready, 1);
        chk("mid_done", m_done, 0);
        step();
        chk("mid_done_after", m_done, 0);

        load_valid = 1'b1; parallel_in = 8'h00;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("zero_bit%0d", i), m_sout, 0);
            chk($sformatf("zero_valid%0d", i), m_svalid, 1);
            chk($sformatf("zero_last%0d", i), m_last, (i == FL - 1));
            step();
        end
        chk("zero_done", m_done, 1);

`ifdef PISO_PARITY_EN
        // Parity of 0x07 is 1
        step();
        load_valid = 1'b1; parallel_in = 8'h07;
        step();
        load_valid = 1'b0;
        repeat (8) step();
        chk("par07_bit", m_sout, 1);
        chk("par07_last", m_last, 1);
        step();
        chk("par07_done", m_done, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piso_serializer_param.md
Name: piso_serializer_param

Overview:
Parametrised parallel-in/serial-out serializer; successor to the fixed 8-bit PISO shift register. Adds configurable width and bit order, a valid/ready load handshake, bit counting with frame-complete signalling, a clock-enable stall, and gap-free back-to-back frames. Sits between a parallel word source and a serial line driver / bit-serial datapath.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
IDLE_LEVEL, 0, serial_out level when no frame is active

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
enable  input  1  shift enable; low = stall in SHIFT state
load_valid  input  1  parallel_in holds a word to send
load_ready  output  1  block accepts a word this cycle
parallel_in  input  WIDTH  word to serialize
shift_reg  output  WIDTH  current shift register contents (debug/visibility)
serial_out  output  1  serial data bit
serial_valid  output  1  serial_out carries a frame bit
last_bit  output  1  current bit is the final bit of the frame
busy  output  1  frame in progress (state == SHIFT)
frame_done  output  1  one-cycle pulse after a frame's final bit is consumed

Behaviour:
- One clock, clk; reset synchronous, active-high, named reset. Reset has priority over all inputs.
- Reset values: state IDLE, shift_reg 0, bit_cnt 0, frame_done 0; serial_out = IDLE_LEVEL, serial_valid 0, last_bit 0, busy 0, load_ready 1.
- States: IDLE, SHIFT. bit_cnt width = clog2(FRAME_LEN+1); FRAME_LEN = WIDTH (WIDTH+1 with parity option).
- load_ready (combinational) = IDLE | (last_bit & enable). In IDLE, readiness does not depend on enable.
- Accept = load_valid & load_ready at a clk edge: shift_reg <= parallel_in, bit_cnt <= 0, state <= SHIFT.
- serial_out (combinational): SHIFT ? (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]) : IDLE_LEVEL. serial_valid = busy = (state == SHIFT).
- Latency: first bit on serial_out the cycle after accept.
- SHIFT with enable=1: shift_reg shifts by one toward the output end, zero-filled; bit_cnt increments. Each bit is presented for exactly one enabled cycle.
- SHIFT with enable=0: shift_reg, bit_cnt and state hold; serial_out holds the current bit; load_ready 0 (unless IDLE).
- last_bit = SHIFT & (bit_cnt == FRAME_LEN-1).
- Edge with last_bit & enable: if load_valid, reload (back-to-back, no idle cycle); else state <= IDLE.
- frame_done: registered, high for exactly one cycle following each edge where last_bit & enable; it coincides with the next frame's first bit during back-to-back operation.
- load_valid while busy and not last_bit: ignored, word not consumed; the source holds it.
- Reset mid-frame: frame abandoned, no frame_done, outputs at reset values the next cycle.

Optional Feature:
PISO_PARITY_EN. Defined: even parity (XOR of the accepted word) is latched at accept and sent as one extra bit after the data bits. FRAME_LEN = WIDTH+1, and last_bit asserts on the parity bit. Not defined: no parity logic, FRAME_LEN = WIDTH.

Test Plan:
Reset then load 0x96 (WIDTH=8, MSB_FIRST=1, enable=1) -> serial_out 1,0,0,1,0,1,1,0 on 8 consecutive cycles from the cycle after accept; last_bit on the 8th; frame_done pulse on cycle 9; then IDLE at IDLE_LEVEL.
MSB_FIRST=0, load 0x62 -> serial_out 0,1,0,0,0,1,1,0; serial_valid high for exactly 8 cycles.
Back-to-back: 0x96 then 0x62 with load_valid held -> 16 contiguous valid bits, no gap; second accept on the last_bit cycle; frame_done concurrent with the first bit of 0x62.
Stall: 0x96, enable low for 3 cycles after bit 3 -> serial_out holds 1 for 4 cycles; load_ready 0; total frame span 11 cycles, bit sequence unchanged.
Reset asserted at bit 5 of 0x96 -> next cycle busy 0, shift_reg 0, serial_out IDLE_LEVEL, load_ready 1, no frame_done; new load 0x00 then sends 8 zeros.
PISO_PARITY_EN defined: 0x96 -> 8 data bits then parity 0; 0x07 -> parity 1; frame 9 bits; last_bit on the parity bit.
